wb_pipe_mem: RTL and testbench

Pipelined Wishbone B4 slave memory. It is the responder end of the bus that the core's ifetch and load-store masters drive through the arbiter. Programmable fixed read/write response latency and an optional stall injector exercise the masters' pipelining and back-pressure paths. It drops into the slave slot of the arbiter in place of the single-cycle RAM.

---
 rtl/wb_pipe_mem.sv | 115 +++++++++++
 tb/tb_wb_pipe_mem.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_mem.sv
// Pipelined Wishbone B4 slave memory with fixed response latency.
// Optional stall injector enabled by defining WB_MEM_STALL_INJ_EN.
module wb_pipe_mem #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 30,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [DATA_W-1:0]   dat_i,
    input  logic                stb_i,
    input  logic                cyc_i,
    output logic                ack_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   dat_o,
    output logic                stall_o
);

    localparam int NLANE = DATA_W / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic                  acc;
    logic                  in_rng;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     rd_data;

    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] e_q;
    logic [DATA_W-1:0]  d_q [LATENCY];
    logic [LATENCY-1:0] v_d;
    logic [LATENCY-1:0] e_d;
    logic [DATA_W-1:0]  d_d [LATENCY];

    assign acc     = cyc_i & stb_i & ~stall_o & ~rst_i;
    assign in_rng  = (addr_i >> DEPTH_LOG2) == '0;
    assign idx     = addr_i[DEPTH_LOG2-1:0];
    // Writes and errored requests carry zero data down the pipe.
    assign rd_data = (we_i | ~in_rng) ? '0 : mem_q[idx];

    always_ff @(posedge clk_i) begin
        if (acc && we_i && in_rng) begin
            for (int b = 0; b < NLANE; b++) begin
                if (sel_i[b]) begin
                    mem_q[idx][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        v_d    = '0;
        e_d    = '0;
        v_d[0] = acc;
        e_d[0] = acc & ~in_rng;
        d_d[0] = rd_data;
        for (int i = 1; i < LATENCY; i++) begin
            v_d[i] = v_q[i-1];
            e_d[i] = e_q[i-1];
            d_d[i] = d_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= '0;
            e_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                d_q[i] <= '0;
            end
        end else if (!cyc_i) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
            e_q <= e_d;
            for (int i = 0; i < LATENCY - 1; i++) begin
                d_q[i] <= d_d[i];
            end
            // Output data only moves on an ack so it holds otherwise.
            if (v_d[LATENCY-1] && !e_d[LATENCY-1]) begin
                d_q[LATENCY-1] <= d_d[LATENCY-1];
            end
        end
    end

    assign ack_o = v_q[LATENCY-1] & ~e_q[LATENCY-1];
    assign err_o = v_q[LATENCY-1] & e_q[LATENCY-1];
    assign dat_o = d_q[LATENCY-1];

`ifdef WB_MEM_STALL_INJ_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (cyc_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_o = (lfsr_q[1:0] == 2'b00);
`else
    assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_pipe_mem.sv
// Randomised bench for wb_pipe_mem: latency 2 and 3 instances
// share one bus and are checked against a transaction-level model.
module tb_wb_pipe_mem;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int DL = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    sel;
    logic [DW-1:0] wdat;
    logic          stb;
    logic          cyc;
    logic          ack2, err2, stall2;
    logic          ack3, err3, stall3;
    logic [DW-1:0] dat2, dat3;

    always #5 clk = ~clk;

    wb_pipe_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL),
                  .LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .we_i(we),
        .sel_i(sel), .dat_i(wdat), .stb_i(stb), .cyc_i(cyc),
        .ack_o(ack2), .err_o(err2), .dat_o(dat2), .stall_o(stall2)
    );

    wb_pipe_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL),
                  .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .we_i(we),
        .sel_i(sel), .dat_i(wdat), .stb_i(stb), .cyc_i(cyc),
        .ack_o(ack3), .err_o(err3), .dat_o(dat3), .stall_o(stall3)
    );

    typedef struct {
        int          acc;
        bit          err;
        logic [31:0] d;
    } rec_t;

    rec_t        pend[$];
    logic [31:0] mem_m [4096];
    int          lat[2] = '{2, 3};
    bit          exp_ack[2];
    bit          exp_err[2];
    logic [31:0] exp_dat[2];
    int          edge_n, n_chk, n_fail;
    int          n_acc, n_resp, n_stall;
    bit          stall_s;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        for (int j = 0; j < 2; j++) begin
            exp_ack[j] = 1'b0;
            exp_err[j] = 1'b0;
            exp_dat[j] = '0;
        end
    endtask

    // One rising edge of the bus, seen as transactions.
    task automatic model_edge();
        rec_t r;
        edge_n++;
        if (rst) begin
            model_clear();
            return;
        end
        if (!cyc) begin
            pend.delete();
            for (int j = 0; j < 2; j++) begin
                exp_ack[j] = 1'b0;
                exp_err[j] = 1'b0;
            end
            return;
        end
        if (stb && !stall_s) begin
            r.acc = edge_n;
            r.err = (addr >= 4096);
            r.d   = '0;
            if (!r.err) begin
                if (!we) r.d = mem_m[addr[11:0]];
                else begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) mem_m[addr[11:0]][8*b +: 8] = wdat[8*b +: 8];
                end
            end
            pend.push_back(r);
            n_acc++;
        end
        for (int j = 0; j < 2; j++) begin
            exp_ack[j] = 1'b0;
            exp_err[j] = 1'b0;
            foreach (pend[i]) begin
                if (pend[i].acc + lat[j] - 1 == edge_n) begin
                    exp_err[j] = pend[i].err;
                    exp_ack[j] = !pend[i].err;
                    if (!pend[i].err) exp_dat[j] = pend[i].d;
                end
            end
        end
        while (pend.size() > 0 && pend[0].acc + 2 <= edge_n)
            void'(pend.pop_front());
    endtask

    task automatic check_outs();
        chk("ack_l2", ack2, exp_ack[0]);
        chk("err_l2", err2, exp_err[0]);
        chk("dat_l2", dat2, exp_dat[0]);
        chk("ack_l3", ack3, exp_ack[1]);
        chk("err_l3", err3, exp_err[1]);
        chk("dat_l3", dat3, exp_dat[1]);
`ifdef WB_MEM_STALL_INJ_EN
        chk("stall_eq", stall2, stall3);
`else
        chk("stall_off", stall2, 32'd0);
`endif
        if (ack3 || err3) n_resp++;
    endtask

    task automatic tick();
        stall_s = stall2;
        if (stall_s && cyc) n_stall++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(int k);
        repeat (k) tick();
    endtask

    // Master that holds its request while stalled.
    task automatic req(bit w, logic [AW-1:0] a, logic [3:0] s,
                       logic [31:0] d);
        int n;
        n    = 0;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        addr = a;
        sel  = s;
        wdat = d;
        do begin
            tick();
            n++;
        end while (stall_s && n < 64);
        chk("stall_bound", stall_s, 32'd0);
        stb = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; sel = '0; wdat = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_outs();
        rst = 1'b0;
        idle(2);

        req(1'b1, 30'd5, 4'hF, 32'hDEADBEEF);
        req(1'b0, 30'd5, 4'hF, 32'h0);
        tick();
        chk("rd5_ack2", ack2, 32'd1);
        chk("rd5_dat2", dat2, 32'hDEADBEEF);
        tick();
        chk("rd5_dat3", dat3, 32'hDEADBEEF);

        req(1'b1, 30'd5, 4'b0101, 32'h11223344);
        req(1'b0, 30'd5, 4'hF, 32'h0);
        idle(2);
        chk("lanes_dat3", dat3, 32'hDE22BE44);

        for (int i = 0; i < 4; i++) req(1'b1, AW'(i), 4'hF, 32'hA0 + i);
        idle(3);
        for (int i = 0; i < 4; i++) req(1'b0, AW'(i), 4'hF, 32'h0);
        idle(4);

        req(1'b0, 30'h1000, 4'hF, 32'h0);
        tick();
        chk("oor_err2", err2, 32'd1);
        chk("oor_ack2", ack2, 32'd0);
        req(1'b1, 30'h1000, 4'hF, 32'h55555555);
        req(1'b0, 30'd0, 4'hF, 32'h0);
        idle(2);
        chk("w0_kept", dat3, 32'hA0);
        req(1'b0, 30'h3FFFFFFF, 4'hF, 32'h0);
        idle(3);

        req(1'b0, 30'd1, 4'hF, 32'h0);
        req(1'b0, 30'd2, 4'hF, 32'h0);
        cyc = 1'b0;
        tick();
        chk("drop_ack3", ack3, 32'd0);
        idle(3);

        req(1'b0, 30'd2, 4'hF, 32'h0);
        req(1'b0, 30'd3, 4'hF, 32'h0);
        #2 rst = 1'b1;
        #1;
        model_clear();
        chk("arst_ack2", ack2, 32'd0);
        chk("arst_dat2", dat2, 32'd0);
        chk("arst_err3", err3, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        idle(5);

        for (int i = 0; i < 16; i++) req(1'b1, AW'(i), 4'hF, $urandom);
        for (int it = 0; it < 400; it++) begin
            cyc  = ($urandom_range(0, 19) != 0);
            stb  = $urandom_range(0, 1);
            we   = $urandom_range(0, 1);
            sel  = 4'($urandom_range(0, 15));
            wdat = $urandom;
            if ($urandom_range(0, 9) == 0)
                addr = AW'(4096 + $urandom_range(0, 100000));
            else
                addr = AW'($urandom_range(0, 15));
            tick();
        end
        stb = 1'b0;
        cyc = 1'b1;
        idle(4);

`ifdef WB_MEM_STALL_INJ_EN
        n_acc   = 0;
        n_resp  = 0;
        n_stall = 0;
        for (int i = 0; i < 200; i++)
            req(1'b1, AW'(100 + i), 4'hF, $urandom);
        for (int i = 0; i < 200; i++)
            req(1'b0, AW'(100 + i), 4'hF, 32'h0);
        idle(4);
        chk("stall_seen", (n_stall > 0), 32'd1);
        chk("resp_count", n_resp, n_acc);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
